// File: rtl/instr_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder.
//   instr_cls_e : request class carried on in_cls (values 10..15 are undefined)
//   OP_*        : RV32I base opcodes
//   F7_ALT      : funct7 selecting sub/sra/srai
//   enc_state_e : sequencer states
package instr_enc_pkg;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I_ALU  = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8,
        CLS_LI     = 4'd9
    } instr_cls_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT    = 2'd1,
        ST_EMIT_LO = 2'd2
    } enc_state_e;

endpackage

// File: rtl/rv32_imm_pack.sv
// Places an immediate into its RV32I instruction-format bit positions and
// reports whether the value is representable in that format.
//   cls      : request class (selects I/S/B/U/J layout; LI uses the I layout)
//   imm      : full signed immediate / byte offset
//   imm_bits : immediate bits in position, all other fields zero
//   range_ok : value fits the format (including alignment for B/J)
module rv32_imm_pack
    import instr_enc_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_ok
);

    logic fit12;
    logic fit13;
    logic fit21;

    // A value fits N signed bits when every bit above N-1 equals the sign bit.
    assign fit12 = (imm[31:11] == {21{imm[31]}});
    assign fit13 = (imm[31:12] == {20{imm[31]}});
    assign fit21 = (imm[31:20] == {12{imm[31]}});

    always_comb begin
        imm_bits = '0;
        range_ok = 1'b0;
        case (cls)
            CLS_R: begin
                range_ok = 1'b1;
            end
            CLS_I_ALU, CLS_LOAD, CLS_JALR, CLS_LI: begin
                imm_bits[31:20] = imm[11:0];
                range_ok        = fit12;
            end
            CLS_STORE: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                range_ok        = fit12;
            end
            CLS_BRANCH: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                range_ok        = fit13 & ~imm[0];
            end
            CLS_LUI, CLS_AUIPC: begin
                imm_bits[31:12] = imm[31:12];
                range_ok        = (imm[11:0] == 12'd0);
            end
            CLS_JAL: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
                range_ok        = fit21 & ~imm[0];
            end
            default: begin
                range_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder / sequencer. Accepts decoded fields, emits legal
// 32-bit words with a wrapping IMEM word address; LI expands to lui/addi.
//   clk, rstn            : clock, async active-low reset
//   clr                  : sync clear (drop pending output, address <- 0)
//   in_valid/in_ready    : request handshake
//   in_cls,in_f3,in_alt  : class, funct3, funct7 alternate select
//   in_rd,in_rs1,in_rs2  : register indices
//   in_imm               : signed immediate / offset
//   out_valid/out_ready  : word handshake
//   out_instr, out_addr  : encoded word and its word address
//   err                  : one-cycle pulse for a rejected request
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | ready for a request
// ST_EMIT    | presenting main word, waiting for out_ready
// ST_EMIT_LO | presenting LI low-half addi, waiting for out_ready
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cls,
    input  logic [2:0]        in_f3,
    input  logic              in_alt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    enc_state_e        state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       lo_q, lo_d;
    logic              lo_pend_q, lo_pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic        li_small;
    logic [19:0] li_hi;
    logic [3:0]  pack_cls;
    logic [31:0] pack_imm;
    logic [31:0] pack_bits;
    logic        pack_ok;
    logic [31:0] lo_bits;
    logic        lo_ok;
    logic        is_shift;
    logic        legal;
    logic        lo_needed;
    logic [31:0] enc_word;
    logic [31:0] lo_word;

    assign li_small = (in_imm[31:11] == {21{in_imm[31]}});
    // Upper part rounded so the sign-extended addi low half restores the value.
    assign li_hi    = in_imm[31:12] + {19'd0, in_imm[11]};
    assign is_shift = (in_cls == CLS_I_ALU) && ((in_f3 == 3'b001) || (in_f3 == 3'b101));

    always_comb begin
        pack_cls = in_cls;
        pack_imm = in_imm;
        if (in_cls == CLS_LI && !li_small) begin
            pack_cls = CLS_LUI;
            pack_imm = {li_hi, 12'd0};
        end
    end

    rv32_imm_pack u_pack_main (
        .cls      (pack_cls),
        .imm      (pack_imm),
        .imm_bits (pack_bits),
        .range_ok (pack_ok)
    );

    rv32_imm_pack u_pack_lo (
        .cls      (CLS_LI),
        .imm      ({{20{in_imm[11]}}, in_imm[11:0]}),
        .imm_bits (lo_bits),
        .range_ok (lo_ok)
    );

    always_comb begin
        legal = 1'b0;
        case (in_cls)
            CLS_R:      legal = ~in_alt | (in_f3 == 3'b000) | (in_f3 == 3'b101);
            CLS_I_ALU:  legal = is_shift ? ((in_imm[31:5] == 27'd0) & (~in_alt | (in_f3 == 3'b101)))
                                         : (pack_ok & ~in_alt);
            CLS_LOAD:   legal = pack_ok & ~in_alt & (in_f3 != 3'b011) & (in_f3 != 3'b110) & (in_f3 != 3'b111);
            CLS_STORE:  legal = pack_ok & ~in_alt & (in_f3 <= 3'b010);
            CLS_BRANCH: legal = pack_ok & ~in_alt & (in_f3 != 3'b010) & (in_f3 != 3'b011);
            CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR:
                        legal = pack_ok & ~in_alt;
            CLS_LI:     legal = ~in_alt & lo_ok;
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        enc_word = pack_bits;
        case (in_cls)
            CLS_R:      enc_word = {(in_alt ? F7_ALT : 7'd0), in_rs2, in_rs1, in_f3, in_rd, OP_R};
            CLS_I_ALU: begin
                enc_word = pack_bits | {12'd0, in_rs1, in_f3, in_rd, OP_IMM};
                if (in_alt) enc_word[31:25] = enc_word[31:25] | F7_ALT;
            end
            CLS_LOAD:   enc_word = pack_bits | {12'd0, in_rs1, in_f3, in_rd, OP_LOAD};
            CLS_STORE:  enc_word = pack_bits | {7'd0, in_rs2, in_rs1, in_f3, 5'd0, OP_STORE};
            CLS_BRANCH: enc_word = pack_bits | {7'd0, in_rs2, in_rs1, in_f3, 5'd0, OP_BRANCH};
            CLS_LUI:    enc_word = pack_bits | {20'd0, in_rd, OP_LUI};
            CLS_AUIPC:  enc_word = pack_bits | {20'd0, in_rd, OP_AUIPC};
            CLS_JAL:    enc_word = pack_bits | {20'd0, in_rd, OP_JAL};
            CLS_JALR:   enc_word = pack_bits | {12'd0, in_rs1, 3'b000, in_rd, OP_JALR};
            CLS_LI:     enc_word = pack_bits | {20'd0, in_rd, (li_small ? OP_IMM : OP_LUI)};
            default:    enc_word = '0;
        endcase
    end

    assign lo_word   = lo_bits | {12'd0, in_rd, 3'b000, in_rd, OP_IMM};
    assign lo_needed = (in_cls == CLS_LI) && !li_small && (in_imm[11:0] != 12'd0);

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        lo_d      = lo_q;
        lo_pend_d = lo_pend_q;
        addr_d    = addr_q;
        err_d     = 1'b0;
        if (clr) begin
            state_d   = ST_IDLE;
            lo_pend_d = 1'b0;
            addr_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (legal) begin
                            instr_d   = enc_word;
                            lo_d      = lo_word;
                            lo_pend_d = lo_needed;
                            state_d   = ST_EMIT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (lo_pend_q) begin
                            instr_d   = lo_q;
                            lo_pend_d = 1'b0;
                            state_d   = ST_EMIT_LO;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_EMIT_LO: begin
                    if (out_ready) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            lo_q      <= '0;
            lo_pend_q <= 1'b0;
            addr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            lo_q      <= lo_d;
            lo_pend_q <= lo_pend_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) & ~clr;
    assign out_valid = (state_q != ST_IDLE);
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors plus randomized requests checked
// against a field-level RV32I reference model.
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_cls = '0;
    logic [2:0]    in_f3 = '0;
    logic          in_alt = 1'b0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [31:0]   in_imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_addr = 0;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cls    (in_cls),
        .in_f3     (in_f3),
        .in_alt    (in_alt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: legality from numeric ranges, words built field by field.
    function automatic void ref_model(input logic [3:0] cls, input logic [2:0] f3, input bit alt,
                                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [31:0] imm, output bit ok,
                                      output logic [31:0] w0, output logic [31:0] w1, output int n);
        int          si;
        bit          in12;
        logic [31:0] hi;
        si   = $signed(imm);
        in12 = (si >= -2048) && (si <= 2047);
        ok   = 1'b0;
        w0   = '0;
        w1   = '0;
        n    = 1;
        case (cls)
            4'd0: begin
                ok = !alt || f3 == 3'd0 || f3 == 3'd5;
                w0 = {(alt ? 7'h20 : 7'h00), rs2, rs1, f3, rd, 7'h33};
            end
            4'd1: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    ok = (imm < 32) && (!alt || f3 == 3'd5);
                    w0 = {(alt ? 7'h20 : 7'h00), imm[4:0], rs1, f3, rd, 7'h13};
                end else begin
                    ok = in12 && !alt;
                    w0 = {imm[11:0], rs1, f3, rd, 7'h13};
                end
            end
            4'd2: begin
                ok = in12 && !alt && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                w0 = {imm[11:0], rs1, f3, rd, 7'h03};
            end
            4'd3: begin
                ok = in12 && !alt && (f3 <= 3'd2);
                w0 = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
            end
            4'd4: begin
                ok = !alt && (si % 2 == 0) && (si >= -4096) && (si <= 4094) && !(f3 inside {3'd2, 3'd3});
                w0 = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
            end
            4'd5, 4'd6: begin
                ok = !alt && (imm % 4096 == 0);
                w0 = {imm[31:12], rd, (cls == 4'd5 ? 7'h37 : 7'h17)};
            end
            4'd7: begin
                ok = !alt && (si % 2 == 0) && (si >= -1048576) && (si <= 1048574);
                w0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
            end
            4'd8: begin
                ok = in12 && !alt;
                w0 = {imm[11:0], rs1, 3'b000, rd, 7'h67};
            end
            4'd9: begin
                ok = !alt;
                if (in12) begin
                    w0 = {imm[11:0], 5'd0, 3'd0, rd, 7'h13};
                end else begin
                    hi = imm + 32'h800;
                    w0 = {hi[31:12], rd, 7'h37};
                    if (imm[11:0] != 12'd0) begin
                        n  = 2;
                        w1 = {imm[11:0], rd, 3'd0, rd, 7'h13};
                    end
                end
            end
            default: ok = 1'b0;
        endcase
    endfunction

    // Issue one request and drain its words. stall: leading out_ready-low
    // cycles per word; pct: out_ready probability afterwards; ng/g0/g1: golden words.
    task automatic do_req(input logic [3:0] cls, input logic [2:0] f3, input bit alt,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input int stall, input int pct,
                          input int ng, input logic [31:0] g0, input logic [31:0] g1);
        bit          ok;
        logic [31:0] w0, w1, w;
        int          n, cyc;
        bit          done, hs;
        ref_model(cls, f3, alt, rd, rs1, rs2, imm, ok, w0, w1, n);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_cls = cls; in_f3 = f3; in_alt = alt;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) begin
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_no_valid", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
            chk("err_one_cycle", {31'd0, err}, 32'd0);
            chk("err_no_valid2", {31'd0, out_valid}, 32'd0);
            chk("err_addr", {30'd0, out_addr}, 32'(exp_addr));
        end else begin
            chk("no_err", {31'd0, err}, 32'd0);
            for (int k = 0; k < n; k++) begin
                w    = (k == 0) ? w0 : w1;
                done = 1'b0;
                cyc  = 0;
                while (!done) begin
                    chk("out_valid", {31'd0, out_valid}, 32'd1);
                    chk("out_instr", out_instr, w);
                    chk("out_addr", {30'd0, out_addr}, 32'(exp_addr));
                    chk("busy_not_ready", {31'd0, in_ready}, 32'd0);
                    if (k < ng) chk("golden", out_instr, (k == 0) ? g0 : g1);
                    if (cyc < stall) out_ready = 1'b0;
                    else out_ready = ($urandom_range(0, 99) < pct);
                    hs = out_ready;
                    @(posedge clk); #1;
                    out_ready = 1'b0;
                    cyc++;
                    if (hs) begin
                        done = 1'b1;
                        exp_addr = (exp_addr + 1) % (1 << AW);
                    end else if (cyc > 60) begin
                        chk("handshake_timeout", 32'd0, 32'd1);
                        done = 1'b1;
                    end
                end
            end
            chk("back_to_idle", {31'd0, out_valid}, 32'd0);
            if (ng > n) chk("extra_words", 32'(n), 32'(ng));
        end
    endtask

    initial begin
        logic [3:0]  r_cls;
        logic [31:0] r_imm;
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr", {30'd0, out_addr}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // directed vectors
        do_req(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 100, 1, 32'h002081B3, 32'h0);
        do_req(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678, 0, 100, 2, 32'h123452B7, 32'h67828293);
        do_req(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h00000FFF, 0, 100, 2, 32'h000012B7, 32'hFFF28293);
        do_req(4'd9, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h00010000, 0, 100, 1, 32'h00010137, 32'h0);
        do_req(4'd9, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFB, 0, 100, 1, 32'hFFB00093, 32'h0);
        do_req(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 3, 100, 1, 32'hFE208CE3, 32'h0);
        do_req(4'd1, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32, 0, 100, 0, 32'h0, 32'h0);
        do_req(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 0, 100, 0, 32'h0, 32'h0);
        do_req(4'd1, 3'd0, 1'b0, 5'd4, 5'd4, 5'd0, 32'd2047, 0, 100, 0, 32'h0, 32'h0);
        do_req(4'd1, 3'd0, 1'b0, 5'd4, 5'd4, 5'd0, 32'd2048, 0, 100, 0, 32'h0, 32'h0);
        do_req(4'd1, 3'd5, 1'b1, 5'd4, 5'd4, 5'd0, 32'd31, 0, 100, 0, 32'h0, 32'h0);
        do_req(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1048574, 0, 100, 0, 32'h0, 32'h0);
        do_req(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1048576, 0, 100, 0, 32'h0, 32'h0);
        do_req(4'd12, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 0, 100, 0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++)
            do_req(4'd0, 3'd0, 1'b0, 5'(i + 1), 5'd1, 5'd2, 32'd0, 0, 50, 0, 32'h0, 32'h0);

        // clr during the LI low half
        in_valid = 1'b1; in_cls = 4'd9; in_f3 = 3'd0; in_alt = 1'b0;
        in_rd = 5'd5; in_imm = 32'h12345678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("clr_hi_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("clr_lo_instr", out_instr, 32'h67828293);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_drops_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_addr_zero", {30'd0, out_addr}, 32'd0);
        chk("clr_blocks_ready", {31'd0, in_ready}, 32'd0);
        clr = 1'b0;
        #1;
        chk("clr_release_ready", {31'd0, in_ready}, 32'd1);
        exp_addr = 0;
        do_req(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 0, 100, 1, 32'h402081B3, 32'h0);

        // async reset while a word is pending
        in_valid = 1'b1; in_cls = 4'd0; in_f3 = 3'd0; in_alt = 1'b0;
        in_rd = 5'd7; in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        chk("mid_rst_addr", {30'd0, out_addr}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_addr = 0;
        @(posedge clk); #1;

        // randomized requests
        for (int i = 0; i < 300; i++) begin
            r_cls = 4'($urandom_range(0, 11));
            case ($urandom_range(0, 5))
                0: r_imm = $urandom_range(0, 4095) - 32'd2048;
                1: r_imm = $urandom_range(0, 40);
                2: r_imm = $urandom;
                3: r_imm = $urandom & 32'hFFFFF000;
                4: r_imm = $urandom_range(0, 8191) - 32'd4096;
                default: r_imm = $urandom_range(0, 4194303) - 32'd2097152;
            endcase
            do_req(r_cls, 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   r_imm, 0, 50, 0, 32'h0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
